// File: rtl/mem_arbiter_if.sv
// Bundle between two requesters (instruction and data ports), the arbiter and
// one shared memory. The slave modport is the arbiter side; master is the environment side.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [15:0]           i_rdata;
   logic                  i_done;
   logic                  d_req;
   logic                  d_wr;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [15:0]           d_wdata;
   logic [15:0]           d_rdata;
   logic                  d_done;
   logic                  mem_enable;
   logic                  mem_wr;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [15:0]           mem_wdata;
   logic [15:0]           mem_rdata;
   logic                  busy;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      output i_rdata, i_done, d_rdata, d_done,
      output mem_enable, mem_wr, mem_addr, mem_wdata, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      input  i_rdata, i_done, d_rdata, d_done,
      input  mem_enable, mem_wr, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for one shared memory. Data port wins ties, but after two
// data grants in a row the waiting instruction port gets the next grant.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LOAD_CNT   = 4'(LATENCY - 1);
   localparam logic [1:0] STREAK_MAX = 2'd2;

   state_t                r_state;
   state_t                w_state_next;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_next;
   logic [1:0]            r_streak;
   logic [1:0]            w_streak_next;
   logic                  r_owner_d;
   logic                  r_wr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [15:0]           r_wdata;
   logic [15:0]           r_i_rdata;
   logic [15:0]           r_d_rdata;

   logic                  w_grant_d;
   logic                  w_grant_i;
   logic                  w_load;
   logic                  w_final;
   logic                  w_in_access;

   assign w_grant_d = bus.d_req && !(bus.i_req && (r_streak == STREAK_MAX));
   assign w_grant_i = bus.i_req && !w_grant_d;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_streak_next = r_streak;
      w_load        = 1'b0;
      w_final       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_grant_d || w_grant_i) begin
               w_state_next = ACCESS;
               w_cnt_next   = LOAD_CNT;
               w_load       = 1'b1;
               if (w_grant_d && bus.i_req)
                  w_streak_next = (r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + 2'd1;
               else
                  w_streak_next = 2'd0;
            end
         end
         ACCESS: begin
            if (r_cnt == 4'd0) begin
               w_state_next = DONE;
               w_final      = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_streak <= 2'd0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_streak <= w_streak_next;
      end
   end

   // Request inputs are sampled only at the grant edge; later changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner_d <= 1'b0;
         r_wr      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= 16'd0;
         r_i_rdata <= 16'd0;
         r_d_rdata <= 16'd0;
      end else begin
         if (w_load) begin
            r_owner_d <= w_grant_d;
            r_wr      <= w_grant_d && bus.d_wr;
            r_addr    <= w_grant_d ? {bus.d_addr[ADDR_WIDTH-1:1], 1'b0}
                                   : {bus.i_addr[ADDR_WIDTH-1:1], 1'b0};
            r_wdata   <= bus.d_wdata;
         end
         if (w_final) begin
            if (!r_owner_d)
               r_i_rdata <= bus.mem_rdata;
            else
               r_d_rdata <= r_wr ? 16'd0 : bus.mem_rdata;
         end
      end
   end

   assign w_in_access    = (r_state == ACCESS);
   assign bus.mem_enable = w_in_access;
   assign bus.mem_wr     = w_final && r_wr;
   assign bus.mem_addr   = w_in_access ? r_addr  : '0;
   assign bus.mem_wdata  = w_in_access ? r_wdata : 16'd0;
   assign bus.i_done     = (r_state == DONE) && !r_owner_d;
   assign bus.d_done     = (r_state == DONE) && r_owner_d;
   assign bus.i_rdata    = r_i_rdata;
   assign bus.d_rdata    = r_d_rdata;
   assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=4 instance carries most vectors,
// a LATENCY=1 instance covers the shortest access.
module tb_mem_arbiter;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   mem_arbiter_if #(.ADDR_WIDTH(16)) u_bus  ();
   mem_arbiter_if #(.ADDR_WIDTH(16)) u_bus1 ();

   mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_bus.slave)
   );

   mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One access on the LATENCY=4 instance; the done cycle is counted from the request negedge.
   task automatic run_access(input string tag, input bit is_d, input bit wr,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] exp_addr, input bit drop_mid,
                             output int lat, output int en_cyc, output int wr_cyc,
                             output int bad_addr, output logic [15:0] wr_data);
      bit done_seen;
      lat = 0; en_cyc = 0; wr_cyc = 0; bad_addr = 0; wr_data = 16'd0;
      @(negedge clk);
      if (is_d) begin
         u_bus.d_req = 1'b1; u_bus.d_wr = wr; u_bus.d_addr = addr; u_bus.d_wdata = wdata;
      end else begin
         u_bus.i_req = 1'b1; u_bus.i_addr = addr;
      end
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (drop_mid && k == 2) begin
            u_bus.d_req = 1'b0; u_bus.d_addr = 16'hFFF0; u_bus.d_wdata = 16'h0000;
         end
         if (u_bus.mem_enable) begin
            en_cyc++;
            if (u_bus.mem_addr !== exp_addr) bad_addr++;
         end
         if (u_bus.mem_wr) begin
            wr_cyc++;
            wr_data = u_bus.mem_wdata;
         end
         done_seen = is_d ? u_bus.d_done : u_bus.i_done;
         if (done_seen) begin
            lat = k;
            break;
         end
      end
      u_bus.i_req = 1'b0;
      u_bus.d_req = 1'b0;
      @(negedge clk);
      check({tag, "_done_width"}, {30'd0, u_bus.i_done, u_bus.d_done}, 32'd0);
      check({tag, "_idle"}, {31'd0, u_bus.busy}, 32'd0);
   endtask

   int          lat, en_cyc, wr_cyc, bad_addr, busy_cyc, n_grants;
   logic [15:0] wr_data;
   logic [7:0]  seq [6];
   logic [7:0]  exp_seq [6];
   bit          saw_wr, saw_done;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      u_bus.i_req = 1'b0; u_bus.i_addr = '0; u_bus.d_req = 1'b0; u_bus.d_wr = 1'b0;
      u_bus.d_addr = '0; u_bus.d_wdata = '0; u_bus.mem_rdata = 16'hBEEF;
      u_bus1.i_req = 1'b0; u_bus1.i_addr = '0; u_bus1.d_req = 1'b0; u_bus1.d_wr = 1'b0;
      u_bus1.d_addr = '0; u_bus1.d_wdata = '0; u_bus1.mem_rdata = 16'h1357;
      exp_seq = '{8'h44, 8'h44, 8'h49, 8'h44, 8'h44, 8'h49};

      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, u_bus.busy}, 32'd0);
      check("rst_mem_en", {30'd0, u_bus.mem_enable, u_bus.mem_wr}, 32'd0);
      check("rst_mem_addr", {16'd0, u_bus.mem_addr}, 32'd0);
      check("rst_rdata", {u_bus.i_rdata, u_bus.d_rdata}, 32'd0);
      check("rst_done", {30'd0, u_bus.i_done, u_bus.d_done}, 32'd0);
      rst_n = 1'b1;

      // Instruction read from an odd address: bit 0 is dropped on the memory side.
      run_access("iread", 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0010, 1'b0,
                 lat, en_cyc, wr_cyc, bad_addr, wr_data);
      check("iread_lat", lat, 32'd5);
      check("iread_en_cycles", en_cyc, 32'd4);
      check("iread_addr", bad_addr, 32'd0);
      check("iread_no_wr", wr_cyc, 32'd0);
      check("iread_rdata", {16'd0, u_bus.i_rdata}, 32'h0000BEEF);

      run_access("dwrite", 1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0020, 1'b0,
                 lat, en_cyc, wr_cyc, bad_addr, wr_data);
      check("dwrite_lat", lat, 32'd5);
      check("dwrite_wr_cycles", wr_cyc, 32'd1);
      check("dwrite_wdata", {16'd0, wr_data}, 32'h00001234);
      check("dwrite_addr", bad_addr, 32'd0);
      check("dwrite_rdata", {16'd0, u_bus.d_rdata}, 32'd0);
      check("iread_hold", {16'd0, u_bus.i_rdata}, 32'h0000BEEF);

      // Request dropped and address changed mid-access: the latched address must be used.
      u_bus.mem_rdata = 16'h5A5A;
      run_access("dread_drop", 1'b1, 1'b0, 16'h0031, 16'h0000, 16'h0030, 1'b1,
                 lat, en_cyc, wr_cyc, bad_addr, wr_data);
      check("dread_drop_lat", lat, 32'd5);
      check("dread_drop_addr", bad_addr, 32'd0);
      check("dread_drop_en", en_cyc, 32'd4);
      check("dread_drop_rdata", {16'd0, u_bus.d_rdata}, 32'h00005A5A);

      // Both ports requesting continuously.
      u_bus.mem_rdata = 16'h0F0F;
      n_grants = 0;
      @(negedge clk);
      u_bus.d_req = 1'b1; u_bus.d_wr = 1'b0; u_bus.d_addr = 16'h0100;
      u_bus.i_req = 1'b1; u_bus.i_addr = 16'h0200;
      for (int k = 0; k < 200 && n_grants < 6; k++) begin
         @(negedge clk);
         if (u_bus.d_done) begin
            seq[n_grants] = 8'h44;
            n_grants++;
         end else if (u_bus.i_done) begin
            seq[n_grants] = 8'h49;
            n_grants++;
         end
      end
      u_bus.d_req = 1'b0;
      u_bus.i_req = 1'b0;
      check("order_count", n_grants, 32'd6);
      for (int g = 0; g < 6; g++)
         check($sformatf("order_%0d", g), {24'd0, seq[g]}, {24'd0, exp_seq[g]});
      repeat (2) @(negedge clk);
      check("order_rdata", {u_bus.i_rdata, u_bus.d_rdata}, 32'h0F0F0F0F);

      // Reset in the second ACCESS cycle of a write.
      saw_wr = 1'b0;
      saw_done = 1'b0;
      @(negedge clk);
      u_bus.d_req = 1'b1; u_bus.d_wr = 1'b1; u_bus.d_addr = 16'h0050; u_bus.d_wdata = 16'h7777;
      repeat (2) begin
         @(negedge clk);
         if (u_bus.mem_wr) saw_wr = 1'b1;
      end
      check("abort_in_access", {31'd0, u_bus.mem_enable}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, u_bus.busy}, 32'd0);
      check("abort_mem_en", {31'd0, u_bus.mem_enable}, 32'd0);
      u_bus.d_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (u_bus.mem_wr) saw_wr = 1'b1;
         if (u_bus.d_done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      check("abort_no_wr", {31'd0, saw_wr}, 32'd0);
      check("abort_no_done", {31'd0, saw_done}, 32'd0);
      check("abort_rdata", {u_bus.i_rdata, u_bus.d_rdata}, 32'd0);

      run_access("post_rst", 1'b1, 1'b1, 16'h0040, 16'hCAFE, 16'h0040, 1'b0,
                 lat, en_cyc, wr_cyc, bad_addr, wr_data);
      check("post_rst_lat", lat, 32'd5);
      check("post_rst_wr", wr_cyc, 32'd1);
      check("post_rst_wdata", {16'd0, wr_data}, 32'h0000CAFE);

      // Shortest access on the LATENCY=1 instance.
      lat = 0;
      busy_cyc = 0;
      en_cyc = 0;
      @(negedge clk);
      u_bus1.i_req = 1'b1; u_bus1.i_addr = 16'h0003;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (u_bus1.busy) busy_cyc++;
         if (u_bus1.mem_enable) begin
            en_cyc++;
            check("l1_addr", {16'd0, u_bus1.mem_addr}, 32'h00000002);
         end
         if (u_bus1.i_done) begin
            lat = k;
            break;
         end
      end
      u_bus1.i_req = 1'b0;
      @(negedge clk);
      if (u_bus1.busy) busy_cyc++;
      check("l1_lat", lat, 32'd2);
      check("l1_en_cycles", en_cyc, 32'd1);
      check("l1_busy_cycles", busy_cyc, 32'd2);
      check("l1_rdata", {16'd0, u_bus1.i_rdata}, 32'h00001357);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
